// File: rtl/mover_pkg.sv
`default_nettype none
// ============================================================================
// Module : mover_pkg
// Brief  : Shared types and default widths for the register-move sequencer.
// Rev    : 1.0
// ============================================================================
package mover_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_AW = 3;

    typedef enum logic [1:0] {
        OP_MOV  = 2'd0,
        OP_XCHG = 2'd1,
        OP_LDI  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR1  = 2'd1,
        S_WR2  = 2'd2
    } seq_state_e;

endpackage : mover_pkg
`default_nettype wire

// File: rtl/regfile_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module : regfile_move_sequencer
// Brief  : Sequences MOV/XCHG/LDI onto the register file write port, sharing
//          it with a higher-priority external writer.
// Rev    : 1.0
// ============================================================================
module regfile_move_sequencer
    import mover_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_src,
    input  logic [REG_AW-1:0] cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [REG_AW-1:0] rd_id,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              ext_we,
    input  logic [REG_AW-1:0] ext_id,
    input  logic [DATA_W-1:0] ext_data,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_id,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    seq_state_e        state, state_d;
    op_e               op_q, op_d;
    logic [REG_AW-1:0] src_q, src_d, dst_q, dst_d;
    logic [DATA_W-1:0] imm_q, imm_d, tmp_q, tmp_d;
    logic              final_wr;
    logic              rd_busy;
    logic              accept;

    always_comb begin
        state_d   = state;
        op_d      = op_q;
        src_d     = src_q;
        dst_d     = dst_q;
        imm_d     = imm_q;
        tmp_d     = tmp_q;
        wr_en     = 1'b0;
        wr_id     = ext_id;
        wr_data   = ext_data;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        final_wr  = 1'b0;
        accept    = 1'b0;

        // The single read port is owned by a MOV/XCHG source read in S_WR1;
        // otherwise it serves the XCHG destination snapshot for the next accept.
        rd_busy = (state == S_WR1) && ((op_q == OP_MOV) || (op_q == OP_XCHG));
        rd_id   = rd_busy ? src_q : cmd_dst;

        if (!reset) begin
            busy = (state != S_IDLE);

            if (ext_we) begin
                wr_en = 1'b1;
            end else begin
                case (state)
                    S_WR1: begin
                        wr_id = dst_q;
                        case (op_q)
                            OP_MOV: begin
                                wr_en    = 1'b1;
                                wr_data  = rd_data;
                                final_wr = 1'b1;
                            end
                            OP_LDI: begin
                                wr_en    = 1'b1;
                                wr_data  = imm_q;
                                final_wr = 1'b1;
                            end
                            OP_XCHG: begin
                                wr_en   = 1'b1;
                                wr_data = rd_data;
                                state_d = S_WR2;
                            end
                            default: final_wr = 1'b1;
                        endcase
                    end
                    S_WR2: begin
                        wr_en    = 1'b1;
                        wr_id    = src_q;
                        wr_data  = tmp_q;
                        final_wr = 1'b1;
                    end
                    default: ;
                endcase
            end

            // An XCHG cannot be taken while a MOV still needs the read port.
            cmd_ready = (state == S_IDLE) ||
                        (final_wr && !(rd_busy && (op_e'(cmd_op) == OP_XCHG)));

            if (final_wr) begin
                state_d = S_IDLE;
            end

            accept = cmd_valid && cmd_ready;
            if (accept) begin
                op_d    = op_e'(cmd_op);
                src_d   = cmd_src;
                dst_d   = cmd_dst;
                imm_d   = cmd_imm;
                // Forward a same-cycle write so the snapshot sees the newest value.
                tmp_d   = (wr_en && (wr_id == cmd_dst)) ? wr_data : rd_data;
                state_d = (op_e'(cmd_op) == OP_RSVD) ? S_IDLE : S_WR1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            op_q  <= OP_MOV;
            src_q <= '0;
            dst_q <= '0;
            imm_q <= '0;
            tmp_q <= '0;
        end else begin
            state <= state_d;
            op_q  <= op_d;
            src_q <= src_d;
            dst_q <= dst_d;
            imm_q <= imm_d;
            tmp_q <= tmp_d;
        end
    end

endmodule : regfile_move_sequencer
`default_nettype wire

// File: tb/tb_regfile_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_move_sequencer
// Brief  : Directed and randomized checks of the move sequencer with a
//          register file model attached to its ports.
// Rev    : 1.0
// ============================================================================
module tb_regfile_move_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_src;
    logic [2:0]  cmd_dst;
    logic [15:0] cmd_imm;
    logic [2:0]  rd_id;
    logic [15:0] rd_data;
    logic        ext_we;
    logic [2:0]  ext_id;
    logic [15:0] ext_data;
    logic        wr_en;
    logic [2:0]  wr_id;
    logic [15:0] wr_data;
    logic        busy;

    logic [15:0] rf [8];
    logic [15:0] mdl [8];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (wr_en) rf[wr_id] <= wr_data;
    end
    assign rd_data = rf[rd_id];

    regfile_move_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_imm   (cmd_imm),
        .rd_id     (rd_id),
        .rd_data   (rd_data),
        .ext_we    (ext_we),
        .ext_id    (ext_id),
        .ext_data  (ext_data),
        .wr_en     (wr_en),
        .wr_id     (wr_id),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                        input logic [15:0] imm);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_imm   = imm;
    endtask

    task automatic ext_write(input logic [2:0] id, input logic [15:0] data);
        ext_we   = 1'b1;
        ext_id   = id;
        ext_data = data;
        tick();
        ext_we   = 1'b0;
    endtask

    initial begin
        logic [1:0]  op;
        logic [2:0]  s, d;
        logic [15:0] imm, v, t;
        bit          accepted;
        int          waited;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_dst = '0;
        cmd_imm = '0; ext_we = 1'b1; ext_id = 3'd5; ext_data = 16'hFFFF;
        tick(); tick();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0; ext_we = 1'b0;
        for (int i = 0; i < 8; i++) ext_write(3'(i), 16'h0);

        // 1: LDI
        send(2'd2, 3'd0, 3'd3, 16'hBEEF);
        #1;
        chk("t1_ready", cmd_ready, 1);
        chk("t1_idle_busy", busy, 0);
        tick(); cmd_valid = 1'b0; #1;
        chk("t1_busy", busy, 1);
        chk("t1_wr_en", wr_en, 1);
        chk("t1_wr_id", wr_id, 3);
        chk("t1_wr_data", wr_data, 16'hBEEF);
        tick(); #1;
        chk("t1_done_busy", busy, 0);
        chk("t1_done_wr_en", wr_en, 0);
        chk("t1_r3", rf[3], 16'hBEEF);

        // 2: back-to-back MOVs
        ext_write(3'd1, 16'h1111);
        send(2'd0, 3'd1, 3'd5, 16'h0);
        tick();
        send(2'd0, 3'd5, 3'd6, 16'h0);
        #1;
        chk("t2_b2b_ready", cmd_ready, 1);
        chk("t2_wr_id1", wr_id, 5);
        chk("t2_wr_data1", wr_data, 16'h1111);
        tick(); cmd_valid = 1'b0; #1;
        chk("t2_wr_id2", wr_id, 6);
        chk("t2_wr_data2", wr_data, 16'h1111);
        tick(); #1;
        chk("t2_r5", rf[5], 16'h1111);
        chk("t2_r6", rf[6], 16'h1111);

        // 3: XCHG
        ext_write(3'd2, 16'hAAAA);
        ext_write(3'd4, 16'h5555);
        send(2'd1, 3'd4, 3'd2, 16'h0);
        tick(); cmd_valid = 1'b0; #1;
        chk("t3_wr1_ready", cmd_ready, 0);
        chk("t3_wr1_id", wr_id, 2);
        chk("t3_wr1_data", wr_data, 16'h5555);
        tick(); #1;
        chk("t3_wr2_id", wr_id, 4);
        chk("t3_wr2_data", wr_data, 16'hAAAA);
        chk("t3_wr2_ready", cmd_ready, 1);
        tick(); #1;
        chk("t3_r2", rf[2], 16'h5555);
        chk("t3_r4", rf[4], 16'hAAAA);

        // 4: external write stalls a MOV and is observed by it
        ext_write(3'd7, 16'h0);
        send(2'd0, 3'd7, 3'd0, 16'h0);
        tick(); cmd_valid = 1'b0;
        ext_we = 1'b1; ext_id = 3'd7; ext_data = 16'h1234;
        #1;
        chk("t4_ext_id", wr_id, 7);
        chk("t4_stall_ready", cmd_ready, 0);
        chk("t4_stall_busy", busy, 1);
        tick(); ext_we = 1'b0; #1;
        chk("t4_seq_en", wr_en, 1);
        chk("t4_seq_id", wr_id, 0);
        chk("t4_seq_data", wr_data, 16'h1234);
        tick(); #1;
        chk("t4_r0", rf[0], 16'h1234);

        // 5: reset in the second XCHG write
        ext_write(3'd1, 16'h0101);
        ext_write(3'd2, 16'h0202);
        send(2'd1, 3'd2, 3'd1, 16'h0);
        tick(); cmd_valid = 1'b0;
        tick();
        reset = 1'b1; #1;
        chk("t5_rst_wr_en", wr_en, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ready", cmd_ready, 0);
        tick(); reset = 1'b0; #1;
        chk("t5_busy", busy, 0);
        chk("t5_wr_en", wr_en, 0);
        chk("t5_ready", cmd_ready, 1);
        chk("t5_r1", rf[1], 16'h0202);
        chk("t5_r2", rf[2], 16'h0202);

        // 6: self-XCHG and reserved op
        ext_write(3'd3, 16'h3333);
        send(2'd1, 3'd3, 3'd3, 16'h0);
        tick(); cmd_valid = 1'b0;
        tick(); tick(); #1;
        chk("t6_r3", rf[3], 16'h3333);
        send(2'd3, 3'd1, 3'd2, 16'hDEAD);
        #1;
        chk("t6_nop_ready", cmd_ready, 1);
        tick(); cmd_valid = 1'b0; #1;
        chk("t6_nop_wr_en", wr_en, 0);
        chk("t6_nop_busy", busy, 0);

        // Random commands on r0..r6 while r7 takes random external writes
        for (int i = 0; i < 8; i++) begin
            v = 16'($urandom);
            ext_write(3'(i), v);
            mdl[i] = v;
        end
        for (int n = 0; n < 300; n++) begin
            op  = 2'($urandom_range(0, 3));
            s   = 3'($urandom_range(0, 6));
            d   = 3'($urandom_range(0, 6));
            imm = 16'($urandom);
            send(op, s, d, imm);
            accepted = 1'b0;
            waited   = 0;
            while (!accepted && waited < 20) begin
                ext_we   = ($urandom_range(0, 2) == 0);
                ext_id   = 3'd7;
                ext_data = 16'($urandom);
                #1;
                if (cmd_ready) begin
                    accepted = 1'b1;
                    case (op)
                        2'd0: mdl[d] = mdl[s];
                        2'd1: begin t = mdl[d]; mdl[d] = mdl[s]; mdl[s] = t; end
                        2'd2: mdl[d] = imm;
                        default: ;
                    endcase
                end
                if (ext_we) mdl[7] = ext_data;
                tick();
                waited++;
            end
            cmd_valid = 1'b0;
            ext_we    = 1'b0;
            if (!accepted) begin
                chk("rand_accept", accepted, 1);
                break;
            end
        end
        cmd_valid = 1'b0; ext_we = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 8; i++) chk($sformatf("rand_r%0d", i), rf[i], mdl[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_regfile_move_sequencer
`default_nettype wire
